// File: rtl/keypad_scan_if.sv
// keypad_scan_if
// Key-event handshake between the keypad scanner and its consumer (CPU I/O
// register or interrupt logic).
//   key_ack   consumer -> scanner, one-cycle pulse that retires key_valid
//   key_code  scanner -> consumer, accepted key, 4*row + col
//   key_valid scanner -> consumer, sticky until acknowledged
//   key_held  scanner -> consumer, accepted key still physically pressed
//   overrun   scanner -> consumer, a press arrived while key_valid was high
// The scanner uses the master modport, the consumer uses slave.
interface keypad_scan_if;
    logic       key_ack;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    modport master (
        input  key_ack,
        output key_code,
        output key_valid,
        output key_held,
        output overrun
    );

    modport slave (
        output key_ack,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun
    );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 active-low hex keypad one column at a time, debounces over
// whole scan frames and reports one key code per press.
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_row_in   keypad rows, active-low, asynchronous to i_clk
//   o_col_sel  one-cold column drive (column c driven when bit c is 0)
//   kp         key-event handshake (master side of keypad_scan_if)
// Parameters:
//   SCAN_TICKS      clocks each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical frames needed to accept a press/release (1..15)
module keypad_scan #(
    parameter int SCAN_TICKS     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_row_in,
    output logic [3:0]    o_col_sel,
    keypad_scan_if.master kp
);

    localparam int             CNT_W      = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [3:0]     DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    logic [3:0]       r_rowMeta;
    logic [3:0]       r_rowSync;
    logic [CNT_W-1:0] r_dwell;
    logic [1:0]       r_colIdx;
    logic [3:0]       r_colSel;
    logic [3:0]       r_col0Keys;
    logic [3:0]       r_col1Keys;
    logic [3:0]       r_col2Keys;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [3:0]       r_cnt;
    logic [3:0]       r_relCnt;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;
    logic             r_overrun;

    logic             w_sample;
    logic             w_frameEnd;
    logic [15:0]      w_frameKeys;
    logic [4:0]       w_hits;
    logic [3:0]       w_code;
    logic             w_none;
    logic             w_single;
    state_t           w_stateNext;
    logic [3:0]       w_candNext;
    logic [3:0]       w_cntNext;
    logic [3:0]       w_relNext;
    logic             w_accept;

    assign w_sample   = (r_dwell == DWELL_LAST);
    assign w_frameEnd = w_sample && (r_colIdx == 2'd3);

    // Two-flop synchronizer; the rows are asynchronous to the clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rowMeta <= '0;
            r_rowSync <= '0;
        end else begin
            r_rowMeta <= i_row_in;
            r_rowSync <= r_rowMeta;
        end
    end

    // Column dwell counter and one-cold column drive, rotated together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell  <= '0;
            r_colIdx <= 2'd0;
            r_colSel <= 4'b1110;
        end else if (w_sample) begin
            r_dwell  <= '0;
            r_colIdx <= r_colIdx + 2'd1;
            r_colSel <= {r_colSel[2:0], r_colSel[3]};
        end else begin
            r_dwell  <= r_dwell + CNT_W'(1);
        end
    end

    // Columns 0..2 are stored; column 3 is used straight from the
    // synchronizer on the frame-end edge, so no extra frame of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col0Keys <= '0;
            r_col1Keys <= '0;
            r_col2Keys <= '0;
        end else if (w_sample) begin
            case (r_colIdx)
                2'd0:    r_col0Keys <= ~r_rowSync;
                2'd1:    r_col1Keys <= ~r_rowSync;
                2'd2:    r_col2Keys <= ~r_rowSync;
                default: ;
            endcase
        end
    end

    // Frame classification; bit index of w_frameKeys is the key code.
    always_comb begin
        w_frameKeys = '0;
        w_hits      = '0;
        w_code      = '0;
        for (int r = 0; r < 4; r++) begin
            w_frameKeys[4*r + 0] = r_col0Keys[r];
            w_frameKeys[4*r + 1] = r_col1Keys[r];
            w_frameKeys[4*r + 2] = r_col2Keys[r];
            w_frameKeys[4*r + 3] = ~r_rowSync[r];
        end
        for (int i = 0; i < 16; i++) begin
            if (w_frameKeys[i]) begin
                w_hits = w_hits + 5'd1;
                w_code = 4'(i);
            end
        end
    end

    assign w_none   = (w_hits == 5'd0);
    assign w_single = (w_hits == 5'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_relCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_cand   <= w_candNext;
            r_cnt    <= w_cntNext;
            r_relCnt <= w_relNext;
        end
    end

    // Debounce decisions happen only on the frame-end cycle.
    always_comb begin
        w_stateNext = r_state;
        w_candNext  = r_cand;
        w_cntNext   = r_cnt;
        w_relNext   = r_relCnt;
        w_accept    = 1'b0;
        if (w_frameEnd) begin
            case (r_state)
                IDLE: begin
                    if (w_single) begin
                        w_candNext = w_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept    = 1'b1;
                            w_stateNext = PRESSED;
                            w_relNext   = '0;
                        end else begin
                            w_stateNext = DEBOUNCE;
                            w_cntNext   = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!w_single) begin
                        w_stateNext = IDLE;
                    end else if (w_code != r_cand) begin
                        w_candNext = w_code;
                        w_cntNext  = 4'd1;
                    end else if (r_cnt + 4'd1 == DEB_TARGET) begin
                        w_accept    = 1'b1;
                        w_stateNext = PRESSED;
                        w_relNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 4'd1;
                    end
                end
                PRESSED: begin
                    if (!w_none) begin
                        w_relNext = '0;
                    end else if (r_relCnt + 4'd1 == DEB_TARGET) begin
                        w_stateNext = IDLE;
                        w_relNext   = '0;
                    end else begin
                        w_relNext = r_relCnt + 4'd1;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // Event register: a new press beats a simultaneous acknowledge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_keyCode  <= '0;
            r_keyValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_accept) begin
            if (!r_keyValid || kp.key_ack) begin
                r_keyCode  <= w_code;
                r_keyValid <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (kp.key_ack && r_keyValid) begin
            r_keyValid <= 1'b0;
            r_overrun  <= 1'b0;
        end
    end

    assign o_col_sel    = r_colSel;
    assign kp.key_code  = r_keyCode;
    assign kp.key_valid = r_keyValid;
    assign kp.key_held  = (r_state == PRESSED);
    assign kp.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Self-checking bench for keypad_scan with SCAN_TICKS=8, DEBOUNCE_SCANS=3.
// A keypad model turns the set of pressed keys into row levels from the
// column drive. A reference model works per clock from elapsed time since
// reset: which column is sampled when, which keys each frame saw, and how
// many consecutive identical frames have been seen.
module tb_keypad_scan;

    localparam int ST    = 8;
    localparam int DS    = 3;
    localparam int FRAME = 4 * ST;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rowIn;
    logic [3:0]  colSel;
    logic [15:0] pressed;

    keypad_scan_if kIf ();

    keypad_scan #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_row_in  (rowIn),
        .o_col_sel (colSel),
        .kp        (kIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rowIn = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!colSel[c] && pressed[4*r + c]) rowIn[r] = 1'b0;
    end

    int nAsserts;
    int nFail;
    int dutRises;
    logic prevValid;

    always @(negedge clk) begin
        if (kIf.key_valid === 1'b1 && prevValid !== 1'b1) dutRises <= dutRises + 1;
        prevValid <= kIf.key_valid;
    end

    // Reference model state
    int          t;
    logic [15:0] lag1, lag2, fKeys;
    int          runLen, noneLen;
    logic [3:0]  runKey;
    bit          held;
    logic [3:0]  mCode;
    bit          mValid, mOver;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic resetModel();
        t = 0; lag1 = '0; lag2 = '0; fKeys = '0;
        runLen = 0; noneLen = 0; runKey = '0; held = 0;
        mCode = '0; mValid = 0; mOver = 0;
    endtask

    task automatic checkAll();
        logic [3:0] expCol;
        expCol = 4'b1111 ^ (4'b0001 << ((t / ST) % 4));
        checkOutput("col_sel",   16'(colSel),        16'(expCol));
        checkOutput("key_code",  16'(kIf.key_code),  16'(mCode));
        checkOutput("key_valid", 16'(kIf.key_valid), 16'(mValid));
        checkOutput("key_held",  16'(kIf.key_held),  16'(held));
        checkOutput("overrun",   16'(kIf.overrun),   16'(mOver));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_col"},   16'(colSel),        16'h000e);
        checkOutput({tag, "_code"},  16'(kIf.key_code),  16'h0);
        checkOutput({tag, "_valid"}, 16'(kIf.key_valid), 16'h0);
        checkOutput({tag, "_held"},  16'(kIf.key_held),  16'h0);
        checkOutput({tag, "_ovr"},   16'(kIf.overrun),   16'h0);
    endtask

    // One clock: advance the model for the coming edge, clock, then compare.
    task automatic applyStimulus(input bit ack);
        int ones;
        logic [3:0] k;
        bit acc;
        kIf.key_ack = ack;
        acc = 0;
        k = '0;
        if (rst_n) begin
            t++;
            if (t % ST == 0) begin
                int col;
                col = ((t / ST) - 1) % 4;
                // The synchronizer delays what the sample sees by two clocks.
                for (int r = 0; r < 4; r++) fKeys[4*r + col] = lag2[4*r + col];
            end
            if (t % FRAME == 0) begin
                ones = 0;
                for (int i = 0; i < 16; i++)
                    if (fKeys[i]) begin ones++; k = 4'(i); end
                if (ones == 1) begin
                    if (runLen > 0 && runKey == k) runLen++;
                    else begin runKey = k; runLen = 1; end
                    noneLen = 0;
                end else if (ones == 0) begin
                    runLen = 0; noneLen++;
                end else begin
                    runLen = 0; noneLen = 0;
                end
                if (!held && runLen == DS) begin
                    acc = 1; held = 1;
                end else if (held && noneLen == DS) begin
                    held = 0;
                end
            end
            if (acc) begin
                if (!mValid || ack) begin mCode = k; mValid = 1; end
                else mOver = 1;
            end else if (ack && mValid) begin
                mValid = 0; mOver = 0;
            end
            lag2 = lag1;
            lag1 = pressed;
        end
        @(posedge clk);
        @(negedge clk);
        kIf.key_ack = 1'b0;
        checkAll();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0);
    endtask

    initial begin
        int rises0;
        bit hit;
        nAsserts = 0; nFail = 0; dutRises = 0;
        pressed = '0;
        kIf.key_ack = 1'b0;
        rst_n = 1'b1;
        resetModel();

        // Reset state, asynchronous
        #1 rst_n = 1'b0;
        #1 checkReset("reset_async");
        runCycles(3);
        rst_n = 1'b1;

        // Idle scanning: column walk and wrap
        runCycles(2 * FRAME + 5);

        // Clean press of key 9 (row 2, column 1), then release
        pressed = 16'(1) << 9;
        runCycles(4 * FRAME + 10);
        checkOutput("press9_code",  16'(kIf.key_code),  16'd9);
        checkOutput("press9_valid", 16'(kIf.key_valid), 16'd1);
        checkOutput("press9_held",  16'(kIf.key_held),  16'd1);
        pressed = '0;
        runCycles(4 * FRAME + 10);
        checkOutput("rel9_held",  16'(kIf.key_held),  16'd0);
        checkOutput("rel9_valid", 16'(kIf.key_valid), 16'd1);
        applyStimulus(1'b1);
        checkOutput("ack9_valid", 16'(kIf.key_valid), 16'd0);
        runCycles(7);

        // Bouncing key 5, then steady
        rises0 = dutRises;
        for (int i = 0; i < 5; i++) begin
            pressed = (i % 2 == 0) ? (16'(1) << 5) : 16'(0);
            runCycles(20);
        end
        pressed = 16'(1) << 5;
        runCycles(4 * FRAME + 10);
        checkOutput("bounce5_code",   16'(kIf.key_code), 16'd5);
        checkOutput("bounce5_events", 16'(dutRises - rises0), 16'd1);
        pressed = '0;
        runCycles(4 * FRAME + 10);
        applyStimulus(1'b1);

        // Ghost: keys 0 and 15 together, then only key 0
        pressed = 16'h8001;
        runCycles(5 * FRAME);
        checkOutput("ghost_valid", 16'(kIf.key_valid), 16'd0);
        pressed = 16'h0001;
        runCycles(4 * FRAME + 10);
        checkOutput("ghost_code0",  16'(kIf.key_code),  16'd0);
        checkOutput("ghost_valid0", 16'(kIf.key_valid), 16'd1);
        applyStimulus(1'b1);
        pressed = '0;
        runCycles(4 * FRAME + 10);

        // Overrun: key 3 unacknowledged, then key 7
        pressed = 16'(1) << 3;
        runCycles(4 * FRAME + 10);
        pressed = '0;
        runCycles(4 * FRAME + 10);
        pressed = 16'(1) << 7;
        runCycles(4 * FRAME + 10);
        checkOutput("ovr_code",  16'(kIf.key_code),  16'd3);
        checkOutput("ovr_flag",  16'(kIf.overrun),   16'd1);
        checkOutput("ovr_valid", 16'(kIf.key_valid), 16'd1);
        applyStimulus(1'b1);
        checkOutput("ovr_ack_valid", 16'(kIf.key_valid), 16'd0);
        checkOutput("ovr_ack_flag",  16'(kIf.overrun),   16'd0);
        pressed = '0;
        runCycles(4 * FRAME + 10);

        // Ack on the very edge a new press is accepted: the new press wins
        pressed = 16'(1) << 2;
        runCycles(4 * FRAME + 10);
        pressed = '0;
        runCycles(4 * FRAME + 10);
        pressed = 16'(1) << 11;
        hit = 0;
        for (int i = 0; i < 6 * FRAME && !hit; i++) begin
            bit a;
            a = ((t + 1) % FRAME == 0) && (runLen == DS - 1) && (runKey == 4'd11) && mValid;
            applyStimulus(a);
            if (a) hit = 1;
        end
        checkOutput("ackacc_found", 16'(hit), 16'd1);
        checkOutput("ackacc_code",  16'(kIf.key_code),  16'd11);
        checkOutput("ackacc_valid", 16'(kIf.key_valid), 16'd1);
        checkOutput("ackacc_ovr",   16'(kIf.overrun),   16'd0);
        pressed = '0;
        runCycles(4 * FRAME + 10);

        // Reset while key 4 is mid-debounce (key_valid still high from key 11)
        pressed = 16'(1) << 4;
        hit = 0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            applyStimulus(1'b0);
            if (runLen == 2 && runKey == 4'd4) hit = 1;
        end
        checkOutput("midrst_found", 16'(hit), 16'd1);
        runCycles(5);
        #2 rst_n = 1'b0;
        #1 checkReset("midrst_async");
        resetModel();
        runCycles(3);
        rst_n = 1'b1;
        runCycles(2 * FRAME + 1);
        checkOutput("midrst_2frames_valid", 16'(kIf.key_valid), 16'd0);
        runCycles(FRAME);
        checkOutput("midrst_3frames_valid", 16'(kIf.key_valid), 16'd1);
        checkOutput("midrst_3frames_code",  16'(kIf.key_code),  16'd4);
        pressed = '0;
        runCycles(4 * FRAME + 10);
        applyStimulus(1'b1);

        // Randomized key activity with sporadic acknowledges
        for (int n = 0; n < 40; n++) begin
            int kind, dur;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       pressed = '0;
                1, 2:    pressed = 16'(1) << $urandom_range(0, 15);
                default: pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            endcase
            dur = $urandom_range(5, 160);
            for (int i = 0; i < dur; i++) applyStimulus($urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
